// File: rtl/dwchunks_to_bundles_serial_pkg.sv
// Shared constants and state encoding for the DWchunk-to-bundle serial transposer.
// Rows and bundles are both four wide; a full Shadow state is 512 bits.
package dwchunks_to_bundles_serial_pkg;

  localparam int unsigned ROW_W_DEF = 32;
  localparam int unsigned N_ROWS    = 4;
  localparam int unsigned STATE_W   = 512;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/shadow_row_mux4.sv
// Selects bundle k out of the 4x4 row buffer; bundle k is buf[k][3..0],
// with row j in the j-th ROW_W slice of the output.
module shadow_row_mux4
  import dwchunks_to_bundles_serial_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic [N_ROWS-1:0][N_ROWS-1:0][ROW_W-1:0] rows_i,
  input  logic [1:0]                               sel_i,
  output logic [N_ROWS*ROW_W-1:0]                  bundle_o
);

  // Pure register-array select, no arithmetic.
  always_comb begin
    bundle_o = rows_i[0];
    case (sel_i)
      2'd0:    bundle_o = rows_i[0];
      2'd1:    bundle_o = rows_i[1];
      2'd2:    bundle_o = rows_i[2];
      2'd3:    bundle_o = rows_i[3];
      default: bundle_o = rows_i[0];
    endcase
  end

endmodule

// File: rtl/dwchunks_to_bundles_serial.sv
// Collects four DWchunks into a 4x4 row buffer (FILL), then streams the four
// bundles out of the same buffer (DRAIN). The two phases never overlap.
module dwchunks_to_bundles_serial
  import dwchunks_to_bundles_serial_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_ROWS*ROW_W-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [N_ROWS*ROW_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy
);

  state_e                                  state_q, state_d;
  logic [1:0]                              j_q, j_d;
  logic [1:0]                              k_q, k_d;
  logic [N_ROWS-1:0][N_ROWS-1:0][ROW_W-1:0] buf_q;
  logic                                    in_hs_s;
  logic                                    out_hs_s;

  // Handshake strobes; ready/valid come from the state register only.
  assign din_ready  = (state_q == ST_FILL);
  assign dout_valid = (state_q == ST_DRAIN);
  assign in_hs_s    = din_ready & din_valid;
  assign out_hs_s   = dout_valid & dout_ready;
  assign dout_last  = dout_valid & (k_q == 2'd3);
  assign busy       = (state_q == ST_DRAIN) | (j_q != 2'd0);

  // Next-state and beat counters; counters only wrap on the phase change.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      ST_FILL: begin
        if (in_hs_s) begin
          if (j_q == 2'd3) begin
            j_d     = 2'd0;
            state_d = ST_DRAIN;
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          j_d = j_q;
        end
      end
      ST_DRAIN: begin
        if (out_hs_s) begin
          if (k_q == 2'd3) begin
            k_d     = 2'd0;
            state_d = ST_FILL;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d = ST_FILL;
        j_d     = 2'd0;
        k_d     = 2'd0;
      end
    endcase
  end

  // State, counters and row buffer; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      if (in_hs_s) begin
        for (int b = 0; b < int'(N_ROWS); b++) begin
          buf_q[b][j_q] <= din[ROW_W*b +: ROW_W];
        end
      end
    end
  end

  shadow_row_mux4 #(
    .ROW_W (ROW_W)
  ) u_mux (
    .rows_i   (buf_q),
    .sel_i    (k_q),
    .bundle_o (dout)
  );

endmodule

// File: tb/tb_dwchunks_to_bundles_serial.sv
// Scoreboard bench: expected bundles are queued when a state is driven and
// compared whenever the DUT completes an output handshake.
module tb_dwchunks_to_bundles_serial;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   din;
  logic           din_valid;
  logic           din_ready;
  logic [127:0]   dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           dout_last;
  logic           busy;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;

  dwchunks_to_bundles_serial #(.ROW_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // State s holds bundle_b at s[128*b +: 128]; row r_b_j at s[128*b+32*j +: 32].
  function automatic logic [127:0] dwchunk(input logic [511:0] s, input int j);
    logic [127:0] d;
    for (int b = 0; b < 4; b++) d[32*b +: 32] = s[128*b + 32*j +: 32];
    return d;
  endfunction

  task automatic push_state(input logic [511:0] s);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      e.data = s[128*b +: 128];
      e.last = (b == 3);
      sb_q.push_back(e);
    end
  endtask

  // Drive one chunk and hold until it is accepted (bounded).
  task automatic send_chunk(input logic [127:0] d);
    logic ok;
    ok = 1'b0;
    din = d;
    din_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = din_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("din_timeout", 128'(1'b0), 128'(1'b1));
    din_valid = 1'b0;
  endtask

  // Send a full state with optional random idle gaps; busy must stay high in gaps.
  task automatic send_state(input logic [511:0] s, input bit gaps);
    push_state(s);
    for (int j = 0; j < 4; j++) begin
      if (gaps && j > 0) begin
        int g;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
          din = 128'($urandom);
          @(negedge clk);
          check_eq("busy_gap", 128'(busy), 128'(1'b1));
          @(posedge clk);
          #1;
        end
      end
      send_chunk(dwchunk(s, j));
    end
  endtask

  // Wait for DRAIN to end, randomising dout_ready if asked.
  task automatic wait_drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!dout_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!done) check_eq("drain_timeout", 128'(1'b0), 128'(1'b1));
    dout_ready = 1'b1;
  endtask

  // Output monitor: every completed output beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 128'(1'b1), 128'(1'b0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("dout", dout, e.data);
        check_eq("dout_last", 128'(dout_last), 128'(e.last));
      end
    end
  end

  logic [511:0] s_basic;
  logic [511:0] s_rand;

  initial begin
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++)
        s_basic[128*b + 32*j +: 32] = 32'(b*16 + j);

    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check_eq("rst_din_ready", 128'(din_ready), 128'(1'b1));
    check_eq("rst_dout_valid", 128'(dout_valid), 128'(1'b0));
    check_eq("rst_dout_last", 128'(dout_last), 128'(1'b0));
    check_eq("rst_dout", dout, 128'd0);
    check_eq("rst_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #1;

    // Basic back-to-back: 4 output beats on consecutive cycles, last on the 4th
    send_state(s_basic, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("basic_valid", 128'(dout_valid), 128'(1'b1));
      check_eq("basic_last", 128'(dout_last), 128'(i == 3));
      check_eq("basic_din_ready", 128'(din_ready), 128'(1'b0));
    end
    @(negedge clk);
    check_eq("basic_done_valid", 128'(dout_valid), 128'(1'b0));
    check_eq("basic_done_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #1;

    // Backpressure with garbage on din
    dout_ready = 1'b0;
    send_state(s_basic, 1'b0);
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check_eq("bp_dout", dout, s_basic[127:0]);
      check_eq("bp_valid", 128'(dout_valid), 128'(1'b1));
      check_eq("bp_din_ready", 128'(din_ready), 128'(1'b0));
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    wait_drain(1'b0);

    // Bubbles in FILL
    @(posedge clk);
    #1;
    send_state(s_basic, 1'b1);
    wait_drain(1'b0);
    check_eq("bubble_busy_end", 128'(busy), 128'(1'b0));

    // Reset mid-FILL, then a new state
    @(posedge clk);
    #1;
    send_chunk(128'hdead_beef_0000_0001_dead_beef_0000_0002);
    send_chunk(128'hdead_beef_0000_0003_dead_beef_0000_0004);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstfill_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) s_rand[32*i +: 32] = $urandom;
    send_state(s_rand, 1'b0);
    wait_drain(1'b0);

    // Reset in DRAIN
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    send_state(s_rand, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_eq("rstdrain_valid", 128'(dout_valid), 128'(1'b0));
    check_eq("rstdrain_dout", dout, 128'd0);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;

    // Round trip of random states with random output backpressure and bubbles
    for (int it = 0; it < 1000; it++) begin
      for (int i = 0; i < 16; i++) s_rand[32*i +: 32] = $urandom;
      send_state(s_rand, 1'($urandom_range(0, 1)));
      wait_drain(1'b1);
      @(posedge clk);
      #1;
    end

    check_eq("sb_leftover", 128'(sb_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/dwchunks_to_bundles_serial.md
DWCHUNKS_TO_BUNDLES_SERIAL -- requirements
Module: dwchunks_to_bundles_serial

Interface
REQ-001 The block SHALL have parameter ROW_W, default 32, giving the width of one Shadow row.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk SHALL be an input of width 1: the single clock, with all state updated on the rising edge.
REQ-004 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-005 Port din SHALL be an input of width 4*ROW_W: one DWchunk, DWchunk_j = [r3_j | r2_j | r1_j | r0_j], with row rb_j at bits [ROW_W*b +: ROW_W].
REQ-006 Port din_valid SHALL be an input of width 1: din is valid.
REQ-007 Port din_ready SHALL be an output of width 1: the block accepts din.
REQ-008 Port dout SHALL be an output of width 4*ROW_W: one bundle, bundle_b = [rb_3 | rb_2 | rb_1 | rb_0], with row rb_j at bits [ROW_W*j +: ROW_W].
REQ-009 Port dout_valid SHALL be an output of width 1: dout is valid.
REQ-010 Port dout_ready SHALL be an input of width 1: the downstream consumer accepts dout.
REQ-011 Port dout_last SHALL be an output of width 1: asserted with the bundle_3 beat.
REQ-012 Port busy SHALL be an output of width 1: high whenever a partial or complete state is held.

Function
REQ-013 The block SHALL transpose a 512-bit Shadow state (ROW_W=32) from DWchunk order, received serially as DWchunk_0..DWchunk_3, into bundle order, emitted serially as bundle_0..bundle_3.
REQ-014 The block SHALL hold a 4x4 array of ROW_W-bit registers buf[b][j].
REQ-015 An input handshake is a cycle with din_valid and din_ready both high.
REQ-016 On an input handshake with input beat counter j, each buf[b][j] SHALL load din[ROW_W*b +: ROW_W].
REQ-017 An output handshake is a cycle with dout_valid and dout_ready both high.
REQ-018 dout SHALL equal the concatenation of buf[k][3..0], where k is the output beat counter.
REQ-019 dout SHALL be a pure register-array mux, with no combinational path from din to dout.
REQ-020 The block SHALL have two states, FILL and DRAIN.
REQ-021 In FILL, din_ready SHALL be 1 and dout_valid SHALL be 0.
REQ-022 In FILL, j SHALL increment on each input handshake.
REQ-023 On the input handshake with j=3, the block SHALL set j to 0 and move to DRAIN.
REQ-024 In DRAIN, din_ready SHALL be 0 and dout_valid SHALL be 1.
REQ-025 In DRAIN, k SHALL increment on each output handshake.
REQ-026 On the output handshake with k=3, the block SHALL set k to 0 and return to FILL.
REQ-027 dout_last SHALL equal dout_valid AND (k==3).
REQ-028 Latency: dout_valid SHALL rise in the cycle after the fourth input handshake, presenting bundle_0.
REQ-029 Throughput: a full state SHALL take at minimum 8 cycles (4 in, 4 out), with no overlap between FILL and DRAIN.
REQ-030 In DRAIN, din_valid SHALL be ignored, and no buffer write SHALL occur.
REQ-031 In DRAIN, dout and dout_valid SHALL stay stable while dout_ready is low.
REQ-032 In FILL, if din_valid is low, j and buf SHALL hold.
REQ-033 busy SHALL be 1 in DRAIN, and 1 in FILL when j is not 0; otherwise busy SHALL be 0.
REQ-034 The two-bit counters j and k SHALL wrap only through the state transitions above, and SHALL never wrap silently.
REQ-035 din_ready and dout_valid SHALL be decoded from the state register only, never from din_valid or dout_ready.

Reset
REQ-036 Reset SHALL be synchronous and active-high, and SHALL take priority over any handshake in the same cycle.
REQ-037 After reset the block SHALL be in FILL with j=0 and k=0.
REQ-038 After reset every buf entry SHALL be 0.
REQ-039 After reset the outputs SHALL be din_ready=1, dout_valid=0, dout_last=0, dout=0 and busy=0.
REQ-040 Reset mid-FILL or mid-DRAIN SHALL discard the partial state, and the next input beat SHALL be treated as DWchunk_0.

Structure
REQ-041 Shared package SHALL hold ROW_W default 32, the rows/bundles count 4, the state width 512, and the FILL/DRAIN state encoding.
REQ-042 The block SHALL be a single module.
REQ-043 One optional sub-module, shadow_row_mux4, SHALL select bundle k from buf.
REQ-044 The block's transposition SHALL be the exact inverse of the existing bundle-to-DWchunk combinational permutation.

Verification
In the scenarios below, rb_j = 32'h000000bj, e.g. r2_1 = 32'h00000021.
REQ-045 Basic: feed DWchunk_0 = {0x30,0x20,0x10,0x00} through DWchunk_3 back-to-back with dout_ready=1 -> bundle_0={0x03,0x02,0x01,0x00} through bundle_3={0x33,0x32,0x31,0x30} on 4 consecutive cycles starting 1 cycle after the last input; dout_last only on the 4th.
REQ-046 Backpressure: hold dout_ready=0 for 5 cycles in DRAIN -> dout stays bundle_0; din_ready=0 throughout; din_valid=1 with garbage leaves buf unchanged.
REQ-047 Bubbles: random din_valid gaps in FILL -> same output as REQ-045; busy=1 from the first accepted beat until the final output handshake.
REQ-048 Round trip: random 512-bit state through the existing permutation block, serialised into this block, outputs concatenated -> equals the original state; 1000 iterations.
REQ-049 Reset mid-operation: assert rst after 2 input beats, then send a full new state -> output matches the new state only; asserting rst in DRAIN gives dout_valid=0 the next cycle.
